// File: rtl/atm_pin_auth.sv
// Card-session PIN authentication controller: collects keypad digits, checks them
// against the card's stored PIN, tracks failed attempts and drives the idle timer.
module atm_pin_auth #(
  parameter int PIN_DIGITS = 4,
  parameter int MAX_TRIES  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    card_in,
  input  logic [4*PIN_DIGITS-1:0] ref_pin,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  input  logic                    time_up,
  output logic                    start_timer,
  output logic                    auth_ok,
  output logic                    pin_error,
  output logic                    card_locked,
  output logic                    eject,
  output logic [1:0]              tries_left,
  output logic [2:0]              digit_count
);

  localparam int             PIN_W   = 4 * PIN_DIGITS;
  localparam logic [2:0]     FULL    = 3'(PIN_DIGITS);
  localparam logic [1:0]     TRIES0  = 2'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ENTRY, S_CHECK, S_AUTH, S_LOCKED, S_EJECT, S_REMOVE
  } state_t;

  state_t             state_q, state_d;
  logic [PIN_W-1:0]   ref_q, ref_d;
  logic [PIN_W-1:0]   buf_q, buf_d;
  logic [2:0]         count_q, count_d;
  logic [1:0]         tries_q, tries_d;
  logic               miss_q, miss_d;
  logic               st_prev_q;
  logic               start_timer_q, start_timer_d;
  logic               auth_ok_q, auth_ok_d;
  logic               pin_error_q, pin_error_d;
  logic               card_locked_q, card_locked_d;
  logic               eject_q, eject_d;

  logic key_digit, key_clr, key_ent, key_can, tu_live, key_hit;

  assign key_digit = (key_code <= 4'd9);
  assign key_clr   = (key_code == 4'hA);
  assign key_ent   = (key_code == 4'hB);
  assign key_can   = (key_code == 4'hC);
  // The timer lags start_timer by a cycle, so its flag is stale while low and one cycle after.
  assign tu_live   = time_up && start_timer_q && st_prev_q;
  assign key_hit   = key_valid && (state_q inside {S_ENTRY, S_AUTH});

  // NOTE: every register updates with <= so all flops see pre-edge values of each other.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ref_q         <= '0;
      buf_q         <= '0;
      count_q       <= '0;
      tries_q       <= '0;
      miss_q        <= 1'b0;
      st_prev_q     <= 1'b0;
      start_timer_q <= 1'b0;
      auth_ok_q     <= 1'b0;
      pin_error_q   <= 1'b0;
      card_locked_q <= 1'b0;
      eject_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ref_q         <= ref_d;
      buf_q         <= buf_d;
      count_q       <= count_d;
      tries_q       <= tries_d;
      miss_q        <= miss_d;
      st_prev_q     <= start_timer_q;
      start_timer_q <= start_timer_d;
      auth_ok_q     <= auth_ok_d;
      pin_error_q   <= pin_error_d;
      card_locked_q <= card_locked_d;
      eject_q       <= eject_d;
    end
  end

  // NOTE: each variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    buf_d   = buf_q;
    count_d = count_q;
    tries_d = tries_q;
    miss_d  = 1'b0;
    case (state_q)
      S_IDLE:   if (card_in) state_d = S_LOAD;
      S_LOAD: begin
        ref_d   = ref_pin;
        tries_d = TRIES0;
        count_d = '0;
        state_d = S_ENTRY;
      end
      S_ENTRY: begin
        if (key_valid) begin
          if (key_digit) begin
            if (count_q < FULL) begin
              buf_d   = (buf_q << 4) | PIN_W'(key_code);
              count_d = count_q + 3'd1;
            end
          end else if (key_clr) begin
            count_d = '0;
          end else if (key_ent) begin
            if (count_q == FULL) state_d = S_CHECK;
          end else if (key_can) begin
            state_d = S_EJECT;
          end
        end else if (tu_live) begin
          state_d = S_EJECT;
        end
      end
      S_CHECK: begin
        if (buf_q == ref_q) begin
          state_d = S_AUTH;
        end else begin
          tries_d = tries_q - 2'd1;
          miss_d  = 1'b1;
          count_d = '0;
          state_d = (tries_q == 2'd1) ? S_LOCKED : S_ENTRY;
        end
      end
      S_AUTH: begin
        if (key_valid) begin
          if (key_can) state_d = S_EJECT;
        end else if (tu_live) begin
          state_d = S_EJECT;
        end
      end
      S_LOCKED: if (!card_in) state_d = S_IDLE;
      S_EJECT:  state_d = S_REMOVE;
      S_REMOVE: if (!card_in) state_d = S_IDLE;
    endcase
    // Card pulled mid-session abandons everything without an eject.
    if (!card_in && (state_q inside {S_LOAD, S_ENTRY, S_CHECK, S_AUTH})) begin
      state_d = S_IDLE;
      miss_d  = 1'b0;
    end
    if (state_d == S_IDLE) begin
      buf_d   = '0;
      count_d = '0;
      tries_d = '0;
    end
  end

  always_comb begin
    start_timer_d = (state_d inside {S_ENTRY, S_AUTH}) && !key_hit;
    auth_ok_d     = (state_q == S_AUTH) && (state_d == S_AUTH);
    card_locked_d = (state_q == S_LOCKED) && (state_d == S_LOCKED);
    eject_d       = (state_q == S_EJECT);
    pin_error_d   = miss_q && card_in;
  end

  assign start_timer = start_timer_q;
  assign auth_ok     = auth_ok_q;
  assign pin_error   = pin_error_q;
  assign card_locked = card_locked_q;
  assign eject       = eject_q;
  assign tries_left  = tries_q;
  assign digit_count = count_q;

endmodule

// File: tb/tb_atm_pin_auth.sv
// Directed bench for atm_pin_auth (PIN_DIGITS=4, MAX_TRIES=3) with hand-computed expectations.
module tb_atm_pin_auth;

  logic        clk = 1'b0;
  logic        rst, card_in, key_valid, time_up;
  logic [15:0] ref_pin;
  logic [3:0]  key_code;
  logic        start_timer, auth_ok, pin_error, card_locked, eject;
  logic [1:0]  tries_left;
  logic [2:0]  digit_count;

  int n_vec = 0;
  int n_err = 0;

  atm_pin_auth #(.PIN_DIGITS(4), .MAX_TRIES(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .card_in     (card_in),
    .ref_pin     (ref_pin),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .time_up     (time_up),
    .start_timer (start_timer),
    .auth_ok     (auth_ok),
    .pin_error   (pin_error),
    .card_locked (card_locked),
    .eject       (eject),
    .tries_left  (tries_left),
    .digit_count (digit_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; return 1ns after it so outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic start_card(input logic [15:0] pin);
    ref_pin = pin;
    card_in = 1'b1;
    tick();  // IDLE -> LOAD
    tick();  // LOAD -> ENTRY
  endtask

  task automatic remove_card();
    card_in = 1'b0;
    tick();
    tick();
  endtask

  function automatic logic [15:0] outs();
    return {6'd0, start_timer, auth_ok, pin_error, card_locked, eject, tries_left, digit_count};
  endfunction

  initial begin
    rst = 1'b1; card_in = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    time_up = 1'b0; ref_pin = 16'h0;
    tick();
    tick();
    check("reset_outs", outs(), 16'h0);
    rst = 1'b0;
    tick();
    check("idle_no_card", outs(), 16'h0);

    // Correct PIN, timer restarts, then cancel from AUTH.
    start_card(16'h1234);
    check("load_tries", 16'(tries_left), 16'd3);
    check("entry_timer_on", 16'(start_timer), 16'd1);
    press(4'd1);
    check("digit1_count", 16'(digit_count), 16'd1);
    check("digit1_restart", 16'(start_timer), 16'd0);
    tick();
    check("restart_one_cycle", 16'(start_timer), 16'd1);
    press(4'd2); press(4'd3); press(4'd4);
    check("four_digits", 16'(digit_count), 16'd4);
    press(4'hB);
    check("check_timer_low", 16'(start_timer), 16'd0);
    tick();
    check("auth_lag", 16'(auth_ok), 16'd0);
    tick();
    check("auth_ok", 16'(auth_ok), 16'd1);
    check("auth_tries", 16'(tries_left), 16'd3);
    press(4'd5);
    check("auth_key_restart", {auth_ok, start_timer}, 16'b10);
    press(4'hC);
    check("cancel_auth_drop", {auth_ok, eject}, 16'b00);
    tick();
    check("cancel_eject", 16'(eject), 16'd1);
    tick();
    check("eject_one_pulse", 16'(eject), 16'd0);
    remove_card();

    // Three wrong entries lock the card.
    start_card(16'h1234);
    for (int i = 0; i < 3; i++) begin
      for (int d = 0; d < 4; d++) press(4'd9);
      press(4'hB);
      tick();
      check("bad_tries", 16'(tries_left), 16'(2 - i));
      check("bad_err_lag", 16'(pin_error), 16'd0);
      tick();
      check("bad_pin_error", 16'(pin_error), 16'd1);
      check("bad_locked", 16'(card_locked), 16'(i == 2));
      tick();
      check("pin_error_pulse", 16'(pin_error), 16'd0);
    end
    press(4'd1);
    check("locked_key_ignored", {start_timer, 3'(digit_count)}, 16'd0);
    tick(); tick();
    check("locked_no_eject", {card_locked, eject}, 16'b10);
    remove_card();
    check("locked_removed", outs(), 16'h0);

    // Clear key, then a dropped fifth digit.
    start_card(16'h5678);
    press(4'd1); press(4'd2); press(4'hA);
    check("clear_count", 16'(digit_count), 16'd0);
    press(4'd5); press(4'd6); press(4'd7); press(4'd8); press(4'hB);
    tick(); tick();
    check("clear_auth", 16'(auth_ok), 16'd1);
    remove_card();
    start_card(16'h1234);
    for (int d = 1; d <= 5; d++) press(4'(d));
    check("fifth_dropped", 16'(digit_count), 16'd4);
    press(4'hB);
    tick(); tick();
    check("fifth_auth", 16'(auth_ok), 16'd1);
    remove_card();

    // Enter with too few digits is ignored; then pull the card mid-entry.
    start_card(16'h1234);
    press(4'd1); press(4'd2); press(4'hB);
    check("short_enter_cnt", 16'(digit_count), 16'd2);
    tick(); tick();
    check("short_enter_stay", {start_timer, auth_ok, 2'(tries_left), 3'(digit_count)}, 16'b1_0_11_010);
    card_in = 1'b0;
    tick();
    check("pull_idle", {eject, 3'(digit_count), start_timer}, 16'd0);
    tick();
    check("pull_no_eject", outs(), 16'h0);

    // Idle timeout in ENTRY, with first-cycle blanking.
    start_card(16'h1234);
    time_up = 1'b1;
    tick();
    check("tu_blanked", {start_timer, eject}, 16'b10);
    tick();
    check("tu_eject_state", {start_timer, eject}, 16'b00);
    tick();
    check("tu_eject", 16'(eject), 16'd1);
    time_up = 1'b0;
    tick();
    check("tu_eject_pulse", 16'(eject), 16'd0);
    tick(); tick();
    check("remove_wait", {start_timer, eject}, 16'd0);
    remove_card();

    // Key beats a same-cycle time_up.
    start_card(16'h1234);
    tick(); tick();
    time_up = 1'b1;
    press(4'd7);
    time_up = 1'b0;
    check("key_beats_tu", {start_timer, eject}, 16'b00);
    tick();
    check("key_beats_tu_on", 16'(start_timer), 16'd1);
    tick();
    check("key_beats_tu_cnt", {eject, 3'(digit_count)}, 16'd1);
    remove_card();

    // Reset while authenticated with the card still present.
    start_card(16'h1234);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hB);
    tick(); tick();
    check("pre_rst_auth", 16'(auth_ok), 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_outs", outs(), 16'h0);
    tick();
    check("rst_load", outs(), 16'h0);
    tick();
    check("rst_reload", {start_timer, 2'(tries_left)}, 16'b1_11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
